// File: rtl/hwpe_dma_loader.sv
// hwpe_dma_loader: preloads the HWPE feature-map and kernel SRAMs from a
// source memory. Phases run in the order fmap half 1, fmap half 2, kernel;
// each read beat is forwarded to the HWPE DMA write port one cycle after it
// arrives, and done pulses once all three phases have completed.
module hwpe_dma_loader #(
    parameter int                ADDR_W     = 16,
    parameter int                SRC_AW     = 32,
    parameter int                LEN_W      = 12,
    parameter logic [ADDR_W-1:0] FMEM_ADDR2 = 16'h0800,
    parameter logic [ADDR_W-1:0] KMEM_BASE  = 16'h1000,
    parameter int                MAX_OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SRC_AW-1:0] fmap_src,
    input  logic [LEN_W-1:0]  fmap_beats,
    input  logic [SRC_AW-1:0] fmap2_off,
    input  logic [SRC_AW-1:0] kern_src,
    input  logic [LEN_W-1:0]  kern_beats,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [SRC_AW-1:0] rd_cmd_addr,
    input  logic              rd_rsp_valid,
    output logic              rd_rsp_ready,
    input  logic [63:0]       rd_rsp_data,
    input  logic              rd_rsp_err,
    output logic              dma_wen,
    output logic [ADDR_W-1:0] dma_wa,
    output logic [63:0]       dma_wd,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, F1, F2, KR, FIN} state_t;

    localparam logic [LEN_W-1:0] OUTST_LIMIT = LEN_W'(MAX_OUTST);
    localparam logic [LEN_W-1:0] ONE         = LEN_W'(1);

    state_t            state;
    logic [SRC_AW-1:0] cfg_fmap_src;
    logic [SRC_AW-1:0] cfg_fmap2_src;
    logic [SRC_AW-1:0] cfg_kern_src;
    logic [LEN_W-1:0]  cfg_fmap_beats;
    logic [LEN_W-1:0]  cfg_kern_beats;
    logic [LEN_W-1:0]  cmd_cnt;
    logic [LEN_W-1:0]  rsp_cnt;

    logic              in_phase;
    logic [LEN_W-1:0]  cur_beats;
    logic [SRC_AW-1:0] cur_src;
    logic [ADDR_W-1:0] cur_dst;
    logic [LEN_W-1:0]  outst;
    logic              cmd_fire;
    logic              rsp_fire;
    logic              rsp_last;
    state_t            next_phase;

    // Select the source/destination bases and beat count of the active phase
    // and work out which phase follows it, skipping zero-length phases.
    always_comb begin
        in_phase   = 1'b0;
        cur_beats  = '0;
        cur_src    = '0;
        cur_dst    = '0;
        next_phase = FIN;
        case (state)
            F1: begin
                in_phase   = 1'b1;
                cur_beats  = cfg_fmap_beats;
                cur_src    = cfg_fmap_src;
                cur_dst    = '0;
                next_phase = F2;
            end
            F2: begin
                in_phase   = 1'b1;
                cur_beats  = cfg_fmap_beats;
                cur_src    = cfg_fmap2_src;
                cur_dst    = FMEM_ADDR2;
                next_phase = (cfg_kern_beats != '0) ? KR : FIN;
            end
            KR: begin
                in_phase   = 1'b1;
                cur_beats  = cfg_kern_beats;
                cur_src    = cfg_kern_src;
                cur_dst    = KMEM_BASE;
                next_phase = FIN;
            end
            default: begin
                in_phase   = 1'b0;
            end
        endcase
    end

    assign outst        = cmd_cnt - rsp_cnt;
    assign rd_cmd_valid = in_phase && (cmd_cnt < cur_beats) && (outst < OUTST_LIMIT);
    assign rd_cmd_addr  = cur_src + (SRC_AW'(cmd_cnt) << 3);
    assign rd_rsp_ready = in_phase;
    assign busy         = (state != IDLE);
    assign done         = (state == FIN);
    assign cmd_fire     = rd_cmd_valid && rd_cmd_ready;
    assign rsp_fire     = rd_rsp_valid && rd_rsp_ready;
    assign rsp_last     = rsp_fire && ((rsp_cnt + ONE) == cur_beats);

    // Phase sequencer: latches the configuration on start, counts commands
    // and responses, and moves on when the last response of a phase lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cfg_fmap_src   <= '0;
            cfg_fmap2_src  <= '0;
            cfg_kern_src   <= '0;
            cfg_fmap_beats <= '0;
            cfg_kern_beats <= '0;
            cmd_cnt        <= '0;
            rsp_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_fmap_src   <= fmap_src;
                        cfg_fmap2_src  <= fmap_src + fmap2_off;
                        cfg_kern_src   <= kern_src;
                        cfg_fmap_beats <= fmap_beats;
                        cfg_kern_beats <= kern_beats;
                        cmd_cnt        <= '0;
                        rsp_cnt        <= '0;
                        if (fmap_beats != '0)
                            state <= F1;
                        else if (kern_beats != '0)
                            state <= KR;
                        else
                            state <= FIN;
                    end
                end
                F1, F2, KR: begin
                    if (rsp_last) begin
                        cmd_cnt <= '0;
                        rsp_cnt <= '0;
                        state   <= next_phase;
                    end else begin
                        if (cmd_fire)
                            cmd_cnt <= cmd_cnt + ONE;
                        if (rsp_fire)
                            rsp_cnt <= rsp_cnt + ONE;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write port and sticky error: each accepted beat is written one cycle
    // later at the phase destination base plus its beat offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_wen <= 1'b0;
            dma_wa  <= '0;
            dma_wd  <= '0;
            err     <= 1'b0;
        end else begin
            dma_wen <= 1'b0;
            if (rsp_fire) begin
                dma_wen <= 1'b1;
                dma_wa  <= cur_dst + (ADDR_W'(rsp_cnt) << 3);
                dma_wd  <= rd_rsp_data;
                if (rd_rsp_err)
                    err <= 1'b1;
            end
            if (state == IDLE && start)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// tb_hwpe_dma_loader: directed bench for hwpe_dma_loader. A source-memory
// model answers read commands after a programmable latency, and the
// expected write stream is built from the load configuration.
module tb_hwpe_dma_loader;

    localparam int ADDR_W    = 16;
    localparam int SRC_AW    = 32;
    localparam int LEN_W     = 12;
    localparam int MAX_OUTST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [SRC_AW-1:0] fmap_src;
    logic [LEN_W-1:0]  fmap_beats;
    logic [SRC_AW-1:0] fmap2_off;
    logic [SRC_AW-1:0] kern_src;
    logic [LEN_W-1:0]  kern_beats;
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [SRC_AW-1:0] rd_cmd_addr;
    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [63:0]       rd_rsp_data;
    logic              rd_rsp_err;
    logic              dma_wen;
    logic [ADDR_W-1:0] dma_wa;
    logic [63:0]       dma_wd;
    logic              busy;
    logic              done;
    logic              err;

    hwpe_dma_loader #(
        .ADDR_W(ADDR_W), .SRC_AW(SRC_AW), .LEN_W(LEN_W),
        .FMEM_ADDR2(16'h0800), .KMEM_BASE(16'h1000), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .fmap_src(fmap_src), .fmap_beats(fmap_beats), .fmap2_off(fmap2_off),
        .kern_src(kern_src), .kern_beats(kern_beats),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
        .dma_wen(dma_wen), .dma_wa(dma_wa), .dma_wd(dma_wd),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } cmd_t;

    typedef struct {
        logic [15:0] wa;
        logic [63:0] wd;
    } wr_t;

    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    int   lat = 2;
    int   ready_pct = 100;
    int   err_idx = -1;
    int   rsp_idx = 0;
    int   cmds_issued = 0;
    int   done_cnt = 0;
    logic exp_err = 1'b0;
    cmd_t pend[$];
    wr_t  exp_q[$];
    wr_t  log_q[$];

    // Content of the source memory: every 64-bit word is derived from its address.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Source memory: accepts commands under random ready, answers in order
    // after the programmed latency; an unaccepted response is dropped.
    always @(negedge clk) begin
        cycle++;
        rd_rsp_valid = 1'b0;
        rd_rsp_err   = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cycle) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = mem_word(pend[0].addr);
            rd_rsp_err   = (rsp_idx == err_idx);
            rsp_idx++;
            void'(pend.pop_front());
        end
        rd_cmd_ready = ($urandom_range(99) < ready_pct);
        if (rd_cmd_valid === 1'b1 && rd_cmd_ready) begin
            pend.push_back('{rd_cmd_addr, cycle + lat});
            cmds_issued++;
        end
        if (!rst)
            checkOutput("outst_limit", 64'(pend.size() + int'(rd_rsp_valid) > MAX_OUTST), 64'd0);
    end

    // Compare process: every DUT write must match the next expected write,
    // and at done the stream must be complete with the expected error flag.
    always @(negedge clk) begin
        if (!rst && dma_wen === 1'b1) begin
            log_q.push_back('{dma_wa, dma_wd});
            if (exp_q.size() == 0) begin
                checkOutput("extra_write", 64'(dma_wa), 64'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                checkOutput("dma_wa", 64'(dma_wa), 64'(w.wa));
                checkOutput("dma_wd", dma_wd, w.wd);
            end
        end
        if (!rst && done === 1'b1) begin
            done_cnt++;
            checkOutput("err_at_done", 64'(err), 64'(exp_err));
            checkOutput("writes_left_at_done", 64'(exp_q.size()), 64'd0);
        end
    end

    // Starts a load and builds the expected write stream from the configuration.
    task automatic applyStimulus(input logic [31:0] fs, input int fb, input logic [31:0] off,
                                 input logic [31:0] ks, input int kb);
        @(negedge clk);
        fmap_src   = fs;
        fmap_beats = LEN_W'(fb);
        fmap2_off  = off;
        kern_src   = ks;
        kern_beats = LEN_W'(kb);
        start      = 1'b1;
        exp_q.delete();
        log_q.delete();
        done_cnt = 0;
        rsp_idx  = 0;
        for (int k = 0; k < fb; k++)
            exp_q.push_back('{16'(8 * k), mem_word(fs + 32'(8 * k))});
        for (int k = 0; k < fb; k++)
            exp_q.push_back('{16'(16'h0800 + 8 * k), mem_word(fs + off + 32'(8 * k))});
        for (int k = 0; k < kb; k++)
            exp_q.push_back('{16'(16'h1000 + 8 * k), mem_word(ks + 32'(8 * k))});
        exp_err = (err_idx >= 0 && err_idx < exp_q.size());
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", 64'(done === 1'b1), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0;
        fmap_src = '0; fmap_beats = '0; fmap2_off = '0; kern_src = '0; kern_beats = '0;
        rd_cmd_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; rd_rsp_err = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_wen", 64'(dma_wen), 64'd0);
        checkOutput("rst_cmd_valid", 64'(rd_cmd_valid), 64'd0);
        checkOutput("rst_rsp_ready", 64'(rd_rsp_ready), 64'd0);
        checkOutput("rst_wa", 64'(dma_wa), 64'd0);
        checkOutput("rst_wd", dma_wd, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] nominal load");
        lat = 2; ready_pct = 100;
        applyStimulus(32'd0, 27, 32'd216, 32'd1024, 128);
        waitDone(2000);
        checkOutput("nom_count", 64'(log_q.size()), 64'd182);
        if (log_q.size() == 182) begin
            checkOutput("nom_w0_wa", 64'(log_q[0].wa), 64'h0000);
            checkOutput("nom_w26_wa", 64'(log_q[26].wa), 64'h00D0);
            checkOutput("nom_w27_wa", 64'(log_q[27].wa), 64'h0800);
            checkOutput("nom_w27_wd", log_q[27].wd, 64'hDEADBE37_000000D8);
            checkOutput("nom_w181_wa", 64'(log_q[181].wa), 64'h13F8);
            checkOutput("nom_w181_wd", log_q[181].wd, 64'hDEADB917_000007F8);
        end
        checkOutput("nom_err", 64'(err), 64'd0);

        $display("[TB] back-pressure load");
        lat = 5; ready_pct = 50;
        applyStimulus(32'd0, 27, 32'd216, 32'd1024, 128);
        waitDone(5000);
        checkOutput("bp_count", 64'(log_q.size()), 64'd182);
        if (log_q.size() == 182)
            checkOutput("bp_w27_wd", log_q[27].wd, 64'hDEADBE37_000000D8);
        lat = 2; ready_pct = 100;

        $display("[TB] zero-length fmap");
        applyStimulus(32'd0, 0, 32'd0, 32'h200, 3);
        waitDone(200);
        checkOutput("zero_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            checkOutput("zero_w0_wa", 64'(log_q[0].wa), 64'h1000);
            checkOutput("zero_w0_wd", log_q[0].wd, 64'hDEADBCEF_00000200);
            checkOutput("zero_w2_wa", 64'(log_q[2].wa), 64'h1010);
        end

        $display("[TB] all lengths zero");
        n = cmds_issued;
        applyStimulus(32'h40, 0, 32'd0, 32'h80, 0);
        checkOutput("allzero_done_next", 64'(done), 64'd1);
        @(negedge clk);
        checkOutput("allzero_done_single", 64'(done), 64'd0);
        checkOutput("allzero_no_cmds", 64'(cmds_issued - n), 64'd0);
        checkOutput("allzero_no_writes", 64'(log_q.size()), 64'd0);

        $display("[TB] overlapping halves");
        applyStimulus(32'd0, 20, 32'd64, 32'h400, 4);
        waitDone(500);
        checkOutput("ovl_count", 64'(log_q.size()), 64'd44);
        if (log_q.size() == 44) begin
            checkOutput("ovl_h2_w0_wa", 64'(log_q[20].wa), 64'h0800);
            checkOutput("ovl_h2_w0_wd", log_q[20].wd, 64'hDEADBEAF_00000040);
        end

        $display("[TB] error and restart");
        err_idx = 59;
        applyStimulus(32'd0, 27, 32'd216, 32'd1024, 128);
        repeat (30) @(negedge clk);
        fmap_beats = 12'd5; kern_beats = 12'd1; kern_src = 32'h7000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(2000);
        checkOutput("err_count", 64'(log_q.size()), 64'd182);
        checkOutput("err_sticky", 64'(err), 64'd1);
        err_idx = -1;
        applyStimulus(32'd0, 1, 32'd8, 32'd64, 1);
        checkOutput("err_cleared", 64'(err), 64'd0);
        waitDone(200);
        checkOutput("restart_count", 64'(log_q.size()), 64'd3);

        $display("[TB] reset mid-load");
        applyStimulus(32'd0, 27, 32'd216, 32'd1024, 128);
        n = 0;
        while (log_q.size() < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midrst_ten_writes", 64'(log_q.size() >= 10), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_wen", 64'(dma_wen), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (12) @(negedge clk);
        applyStimulus(32'd0, 27, 32'd216, 32'd1024, 128);
        waitDone(2000);
        checkOutput("reload_count", 64'(log_q.size()), 64'd182);
        if (log_q.size() == 182) begin
            checkOutput("reload_w0_wa", 64'(log_q[0].wa), 64'h0000);
            checkOutput("reload_w0_wd", log_q[0].wd, 64'hDEADBEEF_00000000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
- Sequencer that preloads the HWPE feature-map and kernel SRAMs before instruction issue. It replaces bench-driven DMA writes.
- Fetches 64-bit beats from a source memory over a valid/ready read channel and drives the existing HWPE DMA write port (dma_wen/dma_wa/dma_wd).
- Load order is fixed: fmap half 1, then fmap half 2, then kernel. It raises done when all three phases have finished.

Parameters:
- ADDR_W, 16, width of the HWPE DMA address (matches `HWPE_ADDR_WIDTH).
- SRC_AW, 32, source memory byte-address width.
- LEN_W, 12, width of the beat-count fields.
- FMEM_ADDR2, 16'h0800, destination base of fmap half 2 (matches `FMEM_ADDR2_START).
- KMEM_BASE, 16'h1000, destination base of the kernel SRAM (matches `KMEM_ADDR_START).
- MAX_OUTST, 4, maximum number of read commands in flight (1..8).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse that begins a load
- fmap_src  in  SRC_AW  source byte address of fmap beat 0
- fmap_beats  in  LEN_W  number of 64-bit beats in each fmap half
- fmap2_off  in  SRC_AW  byte offset from fmap_src to the start of half 2 (overlap allowed)
- kern_src  in  SRC_AW  source byte address of the kernel
- kern_beats  in  LEN_W  number of 64-bit kernel beats
- rd_cmd_valid  out  1  read command valid
- rd_cmd_ready  in  1  read command accepted
- rd_cmd_addr  out  SRC_AW  read byte address
- rd_rsp_valid  in  1  read data valid
- rd_rsp_ready  out  1  read data accept
- rd_rsp_data  in  64  read data
- rd_rsp_err  in  1  read error flag
- dma_wen  out  1  HWPE SRAM write enable
- dma_wa  out  ADDR_W  HWPE SRAM byte address
- dma_wd  out  64  HWPE SRAM write data
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error, cleared on start

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; rd_cmd_valid, rd_rsp_ready, dma_wen, busy, done, err all 0; dma_wa=0; dma_wd=0; all counters 0.
- States and transitions:
  - IDLE: on start, latch all config fields and clear err. Next state is F1; if its beat count is zero, skip forward (see zero-length rule).
  - F1: source base fmap_src, destination base 0.
  - F2: source base fmap_src+fmap2_off, destination base FMEM_ADDR2.
  - KR: source base kern_src, destination base KMEM_BASE.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Zero-length rule: any phase with zero beats is skipped without spending a cycle. Example: all counts zero gives start -> FIN on the next cycle.
- busy=1 in F1, F2, KR and FIN. busy=0 in IDLE.
- start while busy is ignored; latched config is unchanged.
- Command side, within a phase:
  - rd_cmd_addr = phase source base + 8*cmd_cnt.
  - rd_cmd_valid=1 while cmd_cnt < beats and outst < MAX_OUTST.
  - cmd_cnt increments on rd_cmd_valid & rd_cmd_ready.
  - Address and valid stay stable until the handshake completes.
- Response side:
  - rd_rsp_ready=1 whenever state is F1, F2 or KR; responses are never back-pressured.
  - On each rd_rsp_valid, the next cycle registers dma_wen=1, dma_wa = phase destination base + 8*rsp_cnt, dma_wd = rd_rsp_data.
  - Write latency is one cycle from response to dma_wen.
  - dma_wa and dma_wd hold their last values when dma_wen=0.
- Outstanding count: outst = cmd_cnt - rsp_cnt. A same-cycle command and response leave it unchanged.
- Phase change: occurs in the cycle where rsp_cnt reaches beats.
  - Commands for the next phase start at the earliest on the following cycle; phases never overlap.
  - The last write of a phase may be on dma_wen in the same cycle as the first command of the next phase.
- Errors: rd_rsp_err=1 on an accepted response sets err. The beat is still written and the sequence runs to FIN. err stays set until the next accepted start.
- Address arithmetic: addresses wrap modulo 2^SRC_AW (source) and 2^ADDR_W (destination). Overflow is not detected.
- Reset mid-operation: return to IDLE in the next cycle with all outputs at reset values. Responses still in flight after reset are dropped, because rd_rsp_ready=0 in IDLE.
- Throughput: with rd_cmd_ready=1 and response latency L ≤ MAX_OUTST, one beat is written per cycle.

Test Plan:
- Nominal load: fmap_src=0, fmap_beats=27, fmap2_off=216, kern_src=1024, kern_beats=128, ready=1, latency 2.
  - Expect 27 writes to 0x000..0x0D0 carrying source bytes 0..215.
  - Then 27 writes to 0x0800..0x08D0 carrying bytes 216..431.
  - Then 128 writes to 0x1000..0x13F8.
  - Single done pulse; 182 writes total; err=0.
- Back-pressure: rd_cmd_ready random at 50%, response latency 5, MAX_OUTST=4.
  - outst never exceeds 4.
  - Write sequence identical to the nominal case; no beat is lost or duplicated.
- Zero lengths: fmap_beats=0, kern_beats=3.
  - Only 3 writes, at 0x1000/0x1008/0x1010.
  - With all counts zero: done is asserted exactly one cycle after start, with no commands issued.
- Overlapping halves: fmap_beats=20, fmap2_off=64.
  - Half-2 write k carries source beat 8+k.
  - Source beats 8..19 are read twice, once in each phase.
- Error and restart: rd_rsp_err on kernel beat 5.
  - err=1 at done; all 182 writes still occur.
  - A new start clears err; start pulses issued while busy have no effect.
- Reset mid-load: assert rst after 10 fmap writes.
  - Next cycle: busy=0, dma_wen=0.
  - A following start reloads from beat 0 with correct addresses.
